// File: rtl/b01_result_packer.sv
// Result packer: collects serial outp/overflw samples into W-bit words (LSB first),
// buffers completed words in a DEPTH-entry FIFO and counts dropped words and fragments.
module b01_result_packer #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_en,
  input  logic          frame,
  input  logic          outp,
  input  logic          overflw,
  output logic [W-1:0]  word_data,
  output logic          word_ovf,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [CW-1:0] drop_count,
  output logic [CW-1:0] frag_count
);

  // state   | meaning
  // S_EMPTY | no bits collected, bc = 0
  // S_FILL  | 1..W-1 bits held in acc_q, bc_q = bits held
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FILL  = 1'b1
  } state_t;

  localparam int BCW = (W > 1) ? $clog2(W) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BCW-1:0] BC_LAST  = BCW'(W - 1);
  localparam logic [BCW-1:0] BC_ONE   = BCW'(1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  state_t         state_q, state_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           aovf_q, aovf_d;

  logic           word_done;
  logic [W-1:0]   done_data;
  logic           done_ovf;
  logic           frag_evt;

  logic [W-1:0]   mem_data_q [DEPTH];
  logic           mem_ovf_q  [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  frag_q, frag_d;

  logic           pop;
  logic           full;
  logic           push_wr;
  logic           drop_evt;

  // Packer next-state
  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    acc_d     = acc_q;
    aovf_d    = aovf_q;
    word_done = 1'b0;
    done_data = acc_q;
    done_ovf  = aovf_q;
    frag_evt  = 1'b0;
    if (in_en) begin
      if (state_q == S_EMPTY || frame) begin
        // A frame in FILL abandons the held bits; this sample starts the new word.
        frag_evt = (state_q == S_FILL);
        acc_d    = '0;
        acc_d[0] = outp;
        aovf_d   = overflw;
        bc_d     = BC_ONE;
        state_d  = S_FILL;
      end else begin
        done_data[bc_q] = outp;
        done_ovf        = aovf_q | overflw;
        if (bc_q == BC_LAST) begin
          word_done = 1'b1;
          state_d   = S_EMPTY;
          bc_d      = '0;
          acc_d     = '0;
          aovf_d    = 1'b0;
        end else begin
          acc_d  = done_data;
          aovf_d = done_ovf;
          bc_d   = bc_q + 1'b1;
        end
      end
    end
  end

  // FIFO control and event counters
  always_comb begin
    pop      = word_valid & word_ready;
    full     = (count_q == FULL_CNT);
    push_wr  = word_done & (~full | pop);
    drop_evt = word_done & full & ~pop;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    drop_d  = drop_q;
    frag_d  = frag_q;

    if (push_wr) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_wr && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_wr) begin
      count_d = count_q - 1'b1;
    end

    if (drop_evt && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
    if (frag_evt && frag_q != '1) begin
      frag_d = frag_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
      bc_q    <= '0;
      acc_q   <= '0;
      aovf_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      frag_q  <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      acc_q   <= acc_d;
      aovf_q  <= aovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      frag_q  <= frag_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!reset && push_wr) begin
      mem_data_q[wptr_q] <= done_data;
      mem_ovf_q[wptr_q]  <= done_ovf;
    end
  end

  assign word_valid = (count_q != '0);
  assign word_data  = word_valid ? mem_data_q[rptr_q] : '0;
  assign word_ovf   = word_valid ? mem_ovf_q[rptr_q] : 1'b0;
  assign drop_count = drop_q;
  assign frag_count = frag_q;

endmodule

// File: tb/tb_b01_result_packer.sv
// Scoreboard bench for b01_result_packer: a sample-queue reference model predicts words,
// drops and fragments; a negedge monitor compares every presented word and the counters.
module tb_b01_result_packer;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_en;
  logic          frame;
  logic          outp;
  logic          overflw;
  logic          word_ready;
  logic [W-1:0]  word_data;
  logic          word_ovf;
  logic          word_valid;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] frag_count;

  b01_result_packer #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_en      (in_en),
    .frame      (frame),
    .outp       (outp),
    .overflw    (overflw),
    .word_data  (word_data),
    .word_ovf   (word_ovf),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .drop_count (drop_count),
    .frag_count (frag_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W:0] exp_q[$];
  bit         samp_q[$];
  bit         sovf_q[$];
  int         mdl_occ  = 0;
  int         mdl_drop = 0;
  int         mdl_frag = 0;
  bit         mon_en   = 1'b0;

  bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit         pop;
    bit         push;
    logic [W:0] w;
    pop  = 1'b0;
    push = 1'b0;
    w    = '0;
    if (reset) begin
      exp_q.delete();
      samp_q.delete();
      sovf_q.delete();
      mdl_occ  = 0;
      mdl_drop = 0;
      mdl_frag = 0;
    end else begin
      pop = (mdl_occ > 0) && word_ready;
      if (in_en) begin
        if (frame && samp_q.size() > 0) begin
          if (mdl_frag < MAXC) mdl_frag++;
          samp_q.delete();
          sovf_q.delete();
        end
        samp_q.push_back(outp);
        sovf_q.push_back(overflw);
        if (samp_q.size() == W) begin
          for (int k = 0; k < W; k++) begin
            w[k] = samp_q[k];
            w[W] = w[W] | sovf_q[k];
          end
          push = 1'b1;
          samp_q.delete();
          sovf_q.delete();
        end
      end
      if (push) begin
        if (mdl_occ < DEPTH || pop) begin
          exp_q.push_back(w);
          mdl_occ++;
        end else if (mdl_drop < MAXC) begin
          mdl_drop++;
        end
      end
      if (pop) mdl_occ--;
    end
  endtask

  task automatic step(input bit en, input bit fr, input bit o, input bit ov, input bit rd);
    in_en      = en;
    frame      = fr;
    outp       = o;
    overflw    = ov;
    word_ready = rd;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send_word(input bit rd);
    for (int k = 0; k < W; k++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), rd);
  endtask

  task automatic idle(input int n, input bit rd);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
  endtask

  // Monitor: compares the DUT against the scoreboard mid-cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("valid", word_valid, (mdl_occ != 0));
      chk("drop_count", drop_count, mdl_drop);
      chk("frag_count", frag_count, mdl_frag);
      if (!word_valid) chk("idle_out", {word_ovf, word_data}, 0);
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: got %0h expected none at %0t", {word_ovf, word_data}, $time);
        end else begin
          chk("word", {word_ovf, word_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_en = 1'b0; frame = 1'b0; outp = 1'b0; overflw = 1'b0; word_ready = 1'b0;
    @(posedge clock);
    #1;
    do_reset();
    mon_en = 1'b1;
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_ovf", word_ovf, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_frag", frag_count, 0);

    // Basic pack
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("basic_early", word_valid, 0);
      step(1'b1, 1'b0, pat[i], 1'b0, 1'b1);
    end
    chk("basic_valid", word_valid, 1);
    chk("basic_data", word_data, 8'h8D);
    chk("basic_ovf", word_ovf, 0);
    idle(1, 1'b1);
    chk("basic_one_cycle", word_valid, 0);

    // Gapped input, sticky overflow
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, pat[i], (i == 2), 1'b0);
      if (i < 7) idle(1, 1'b0);
    end
    chk("gap_data", word_data, 8'h8D);
    chk("gap_ovf", word_ovf, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, pat[i], 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("gap_data2", word_data, 8'h8D);
    chk("gap_ovf2", word_ovf, 0);
    idle(1, 1'b1);
    chk("gap_empty", word_valid, 0);

    // Back-pressure and drop
    do_reset();
    for (int i = 0; i < 5; i++) send_word(1'b0);
    chk("bp_valid", word_valid, 1);
    chk("bp_drop", drop_count, 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_nogap", word_valid, 1);
      idle(1, 1'b1);
    end
    chk("bp_fifth_absent", word_valid, 0);

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 4; i++) send_word(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("fullpop_drop", drop_count, 0);
    chk("fullpop_valid", word_valid, 1);
    idle(4, 1'b1);
    chk("fullpop_drained", word_valid, 0);

    // Re-frame
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("frame_first", frag_count, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, (i == 0), pat[i], 1'b0, 1'b0);
    chk("reframe_frag", frag_count, 1);
    chk("reframe_data", word_data, 8'h8D);
    chk("reframe_ovf", word_ovf, 0);
    idle(1, 1'b1);

    // Reset mid-operation
    do_reset();
    send_word(1'b0);
    send_word(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
    chk("pre_rst_frag", frag_count, 1);
    do_reset();
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_frag", frag_count, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, pat[i], 1'b0, 1'b0);
    chk("post_rst_data", word_data, 8'h8D);
    idle(1, 1'b1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 4 + MAXC + 5; i++) send_word(1'b0);
    chk("drop_sat", drop_count, MAXC);
    for (int i = 0; i < MAXC + 5; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("frag_sat", frag_count, MAXC);
    idle(DEPTH, 1'b1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 9) < 6));
    idle(2 * DEPTH, 1'b1);
    chk("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
